// File: rtl/wrap_rotator.sv
// wrap_rotator: registered circular rotator with a valid/ready handshake on each side.
// Each accepted word is rotated right or left by an amount k in 0..NPOS-1.
// k comes from the external one-hot control or from the internal one-hot pointer.
// The rotated word appears one cycle after it is accepted.
//
// Ports:
//   Phi1            clock, rising edge
//   Reset_s1        asynchronous reset, active-high
//   in_valid_s1     input word valid
//   in_ready_s1     block can accept a word this cycle
//   instate_s1      input state word
//   shiftcontrol_s1 external one-hot amount: bit NPOS-1-k set selects rotate by k
//   ext_sel_s1      1: use shiftcontrol_s1, 0: use internal pointer
//   dir_s1          0: rotate right, 1: rotate left
//   ptr_adv_s1      advance the internal pointer on accept
//   ptr_clr_s1      synchronous clear of the pointer to no-shift
//   out_valid_s1    output word valid
//   out_ready_s1    downstream accepts the output word
//   outstate_s1     rotated word (registered)
//   ptr_s1          internal pointer, same encoding as shiftcontrol_s1
//   ctrl_err_s1     sticky flag: a malformed external control was used
module wrap_rotator #(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned NPOS  = 3
) (
   input  logic             Phi1,
   input  logic             Reset_s1,
   input  logic             in_valid_s1,
   output logic             in_ready_s1,
   input  logic [WIDTH-1:0] instate_s1,
   input  logic [NPOS-1:0]  shiftcontrol_s1,
   input  logic             ext_sel_s1,
   input  logic             dir_s1,
   input  logic             ptr_adv_s1,
   input  logic             ptr_clr_s1,
   output logic             out_valid_s1,
   input  logic             out_ready_s1,
   output logic [WIDTH-1:0] outstate_s1,
   output logic [NPOS-1:0]  ptr_s1,
   output logic             ctrl_err_s1
);

   localparam int unsigned KW = (NPOS > 2) ? $clog2(NPOS) : 1;
   // The no-shift position is the MSB (k = 0).
   localparam logic [NPOS-1:0] PTR_NO_SHIFT = {1'b1, {(NPOS-1){1'b0}}};

   logic                 accept;
   logic [NPOS-1:0]      sel_ctrl;
   logic                 sel_onehot;
   logic [KW-1:0]        k_hot;
   logic [KW-1:0]        k_amt;
   logic [2*WIDTH-1:0]   dbl_word;
   logic [2*WIDTH-1:0]   dbl_shr;
   logic [2*WIDTH-1:0]   dbl_shl;
   logic [WIDTH-1:0]     rot_word;
   logic                 bad_ctrl;

   assign in_ready_s1 = !out_valid_s1 || out_ready_s1;
   assign accept      = in_valid_s1 && in_ready_s1;

   // The pointer is the source whenever ext_sel_s1 is 0, so the amount always uses the
   // pre-update pointer.
   assign sel_ctrl   = ext_sel_s1 ? shiftcontrol_s1 : ptr_s1;
   assign sel_onehot = $onehot(sel_ctrl);

   always_comb begin
      k_hot = '0;
      for (int j = 0; j < NPOS; j++) begin
         if (sel_ctrl[j]) begin
            k_hot = KW'(NPOS - 1 - j);
         end
      end
   end

   // A zero or multi-hot control falls back to pass-through.
   assign k_amt    = sel_onehot ? k_hot : '0;
   assign bad_ctrl = ext_sel_s1 && !sel_onehot;

   // Rotating through a doubled word avoids a modulo per bit.
   assign dbl_word = {instate_s1, instate_s1};
   assign dbl_shr  = dbl_word >> k_amt;
   assign dbl_shl  = dbl_word << k_amt;
   assign rot_word = dir_s1 ? dbl_shl[2*WIDTH-1:WIDTH] : dbl_shr[WIDTH-1:0];

   always_ff @(posedge Phi1 or posedge Reset_s1) begin
      if (Reset_s1) begin
         out_valid_s1 <= 1'b0;
         outstate_s1  <= '0;
         ctrl_err_s1  <= 1'b0;
      end else begin
         if (accept) begin
            out_valid_s1 <= 1'b1;
            outstate_s1  <= rot_word;
            if (bad_ctrl) begin
               ctrl_err_s1 <= 1'b1;
            end
         end else if (out_ready_s1) begin
            out_valid_s1 <= 1'b0;
         end
      end
   end

   always_ff @(posedge Phi1 or posedge Reset_s1) begin
      if (Reset_s1) begin
         ptr_s1 <= PTR_NO_SHIFT;
      end else if (ptr_clr_s1) begin
         ptr_s1 <= PTR_NO_SHIFT;
      end else if (accept && ptr_adv_s1) begin
         ptr_s1 <= {ptr_s1[0], ptr_s1[NPOS-1:1]};
      end
   end

endmodule

// File: tb/tb_wrap_rotator.sv
// tb_wrap_rotator: directed-vector bench for wrap_rotator (WIDTH=9, NPOS=3).
// Inputs change 1 time unit after a rising edge; outputs are checked at that point.
module tb_wrap_rotator;

   localparam int unsigned WIDTH = 9;
   localparam int unsigned NPOS  = 3;

   logic             Phi1;
   logic             Reset_s1;
   logic             in_valid_s1;
   logic             in_ready_s1;
   logic [WIDTH-1:0] instate_s1;
   logic [NPOS-1:0]  shiftcontrol_s1;
   logic             ext_sel_s1;
   logic             dir_s1;
   logic             ptr_adv_s1;
   logic             ptr_clr_s1;
   logic             out_valid_s1;
   logic             out_ready_s1;
   logic [WIDTH-1:0] outstate_s1;
   logic [NPOS-1:0]  ptr_s1;
   logic             ctrl_err_s1;

   int n_vec;
   int n_miss;

   wrap_rotator #(
      .WIDTH(WIDTH),
      .NPOS (NPOS)
   ) u_dut (
      .Phi1           (Phi1),
      .Reset_s1       (Reset_s1),
      .in_valid_s1    (in_valid_s1),
      .in_ready_s1    (in_ready_s1),
      .instate_s1     (instate_s1),
      .shiftcontrol_s1(shiftcontrol_s1),
      .ext_sel_s1     (ext_sel_s1),
      .dir_s1         (dir_s1),
      .ptr_adv_s1     (ptr_adv_s1),
      .ptr_clr_s1     (ptr_clr_s1),
      .out_valid_s1   (out_valid_s1),
      .out_ready_s1   (out_ready_s1),
      .outstate_s1    (outstate_s1),
      .ptr_s1         (ptr_s1),
      .ctrl_err_s1    (ctrl_err_s1)
   );

   initial Phi1 = 1'b0;
   always #5 Phi1 = ~Phi1;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Phi1);
      #1;
   endtask

   // Test 3 stimulus: expected output and pre-accept pointer per word.
   logic [WIDTH-1:0] t3_out [4];
   logic [NPOS-1:0]  t3_ptr [4];

   initial begin
      n_vec  = 0;
      n_miss = 0;
      t3_out = '{9'h001, 9'h100, 9'h080, 9'h001};
      t3_ptr = '{3'b100, 3'b010, 3'b001, 3'b100};

      Reset_s1        = 1'b1;
      in_valid_s1     = 1'b0;
      instate_s1      = '0;
      shiftcontrol_s1 = '0;
      ext_sel_s1      = 1'b0;
      dir_s1          = 1'b0;
      ptr_adv_s1      = 1'b0;
      ptr_clr_s1      = 1'b0;
      out_ready_s1    = 1'b1;

      // Reset state
      step();
      step();
      check("rst_valid", 16'(out_valid_s1), 16'h0);
      check("rst_out", 16'(outstate_s1), 16'h000);
      check("rst_ptr", 16'(ptr_s1), 16'h4);
      check("rst_err", 16'(ctrl_err_s1), 16'h0);
      check("rst_ready", 16'(in_ready_s1), 16'h1);
      Reset_s1 = 1'b0;

      // 1: external k=1 right
      in_valid_s1     = 1'b1;
      ext_sel_s1      = 1'b1;
      shiftcontrol_s1 = 3'b010;
      dir_s1          = 1'b0;
      instate_s1      = 9'h001;
      step();
      check("t1_valid", 16'(out_valid_s1), 16'h1);
      check("t1_out", 16'(outstate_s1), 16'h100);

      // 2: external k=2 right, then left back
      shiftcontrol_s1 = 3'b001;
      instate_s1      = 9'h003;
      step();
      check("t2_right", 16'(outstate_s1), 16'h180);
      dir_s1     = 1'b1;
      instate_s1 = 9'h180;
      step();
      check("t2_left", 16'(outstate_s1), 16'h003);
      in_valid_s1 = 1'b0;
      step();
      check("t2_drain_valid", 16'(out_valid_s1), 16'h0);
      check("t2_drain_hold", 16'(outstate_s1), 16'h003);

      // 3: internal pointer, advancing, with a malformed (ignored) external control
      ext_sel_s1      = 1'b0;
      shiftcontrol_s1 = 3'b000;
      dir_s1          = 1'b0;
      ptr_adv_s1      = 1'b1;
      instate_s1      = 9'h001;
      in_valid_s1     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("t3_ptr%0d", i), 16'(ptr_s1), 16'(t3_ptr[i]));
         step();
         check($sformatf("t3_out%0d", i), 16'(outstate_s1), 16'(t3_out[i]));
         check($sformatf("t3_valid%0d", i), 16'(out_valid_s1), 16'h1);
      end
      check("t3_ptr_end", 16'(ptr_s1), 16'h2);
      check("t3_err", 16'(ctrl_err_s1), 16'h0);
      in_valid_s1 = 1'b0;
      step();
      check("t3_adv_noacc", 16'(ptr_s1), 16'h2);
      ptr_adv_s1 = 1'b0;
      ptr_clr_s1 = 1'b1;
      step();
      check("t3_clr", 16'(ptr_s1), 16'h4);
      ptr_clr_s1 = 1'b0;

      // 4: backpressure
      ext_sel_s1      = 1'b1;
      shiftcontrol_s1 = 3'b100;
      out_ready_s1    = 1'b0;
      in_valid_s1     = 1'b1;
      instate_s1      = 9'h0AA;
      step();
      check("t4_a_valid", 16'(out_valid_s1), 16'h1);
      check("t4_a_out", 16'(outstate_s1), 16'h0AA);
      instate_s1 = 9'h055;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("t4_stall_ready%0d", i), 16'(in_ready_s1), 16'h0);
         step();
         check($sformatf("t4_stall_out%0d", i), 16'(outstate_s1), 16'h0AA);
         check($sformatf("t4_stall_valid%0d", i), 16'(out_valid_s1), 16'h1);
      end
      out_ready_s1 = 1'b1;
      #1;
      check("t4_release_ready", 16'(in_ready_s1), 16'h1);
      step();
      check("t4_b_out", 16'(outstate_s1), 16'h055);
      check("t4_b_valid", 16'(out_valid_s1), 16'h1);
      in_valid_s1 = 1'b0;
      step();
      check("t4_empty", 16'(out_valid_s1), 16'h0);
      check("t4_err", 16'(ctrl_err_s1), 16'h0);

      // 5: malformed external control
      in_valid_s1     = 1'b1;
      shiftcontrol_s1 = 3'b011;
      instate_s1      = 9'h155;
      step();
      check("t5_multi_out", 16'(outstate_s1), 16'h155);
      check("t5_multi_err", 16'(ctrl_err_s1), 16'h1);
      shiftcontrol_s1 = 3'b000;
      step();
      check("t5_zero_out", 16'(outstate_s1), 16'h155);
      check("t5_zero_err", 16'(ctrl_err_s1), 16'h1);
      shiftcontrol_s1 = 3'b010;
      instate_s1      = 9'h001;
      step();
      check("t5_good_out", 16'(outstate_s1), 16'h100);
      check("t5_sticky", 16'(ctrl_err_s1), 16'h1);

      // 6: async reset mid-cycle with output held, ptr=001, err=1
      ext_sel_s1 = 1'b0;
      ptr_adv_s1 = 1'b1;
      step();
      step();
      ptr_adv_s1   = 1'b0;
      in_valid_s1  = 1'b0;
      out_ready_s1 = 1'b0;
      step();
      check("t6_pre_valid", 16'(out_valid_s1), 16'h1);
      check("t6_pre_ptr", 16'(ptr_s1), 16'h1);
      check("t6_pre_err", 16'(ctrl_err_s1), 16'h1);
      #2;
      Reset_s1 = 1'b1;
      #1;
      check("t6_valid", 16'(out_valid_s1), 16'h0);
      check("t6_ptr", 16'(ptr_s1), 16'h4);
      check("t6_err", 16'(ctrl_err_s1), 16'h0);
      check("t6_out", 16'(outstate_s1), 16'h000);
      #2;
      Reset_s1     = 1'b0;
      out_ready_s1 = 1'b1;
      step();
      check("t6_no_output", 16'(out_valid_s1), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
